// File: rtl/arith_pkg.sv
// Shared types and sign helpers for the sequential arithmetic unit.
// Helpers work on a 64-bit word; callers zero-extend and truncate, so WIDTH <= 64.
package arith_pkg;

   localparam int MAX_W = 64;

   typedef logic [MAX_W-1:0] word_t;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      MUL = 3'd2,
      DIV = 3'd3,
      MOD = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic word_t neg_w(input word_t x);
      return ~x + word_t'(1);
   endfunction

   // is_neg is the operand's sign bit (already qualified by signed mode)
   function automatic word_t abs_w(input word_t x, input logic is_neg);
      return is_neg ? neg_w(x) : x;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider over unsigned magnitudes, one quotient bit per step.
// The caller supplies the iteration count through step/last.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step,
   input  logic             last,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             dz
);

   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH:0]   trial;
   logic             fits;

   // quo starts as the dividend and is shifted out MSB-first while quotient bits shift in
   assign trial = {rem, quo[WIDTH-1]};
   assign fits  = trial >= {1'b0, dvs_r};
   assign done  = busy & step & last;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= 1'b0;
         quo   <= '0;
         rem   <= '0;
         dvs_r <= '0;
         dz    <= 1'b0;
      end else if (start) begin
         busy  <= 1'b1;
         quo   <= dividend;
         rem   <= '0;
         dvs_r <= divisor;
         dz    <= (divisor == '0);
      end else if (busy && step) begin
         rem <= fits ? WIDTH'(trial - {1'b0, dvs_r}) : trial[WIDTH-1:0];
         quo <= {quo[WIDTH-2:0], fits};
         if (last)
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked add/sub/mul/div/mod unit; mul and div iterate over operand magnitudes.
//  state | meaning
//  IDLE  | in_ready=1, waiting for operands
//  BUSY  | WIDTH mul/div iterations, counted by cnt_r
//  DONE  | out_valid=1, result held until out_ready
module seq_arith_unit
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_dz
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t           state, state_nx;
   op_t              op_r;
   logic [WIDTH-1:0] a_r, fast_r, acc_r, mc_r, mp_r;
   logic             a_neg_r, prod_neg_r;
   logic [CNT_W-1:0] cnt_r;

   logic             accept, in_iter, cnt_last;
   logic             a_neg_in, b_neg_in;
   logic [WIDTH-1:0] a_mag_in, b_mag_in, fast_res;
   logic [WIDTH-1:0] res_c;
   logic             dz_c;

   logic             div_start, div_step, div_busy, div_done, div_dz;
   logic [WIDTH-1:0] div_quo, div_rem;

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic n);
      return n ? WIDTH'(neg_w(word_t'(m))) : m;
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign in_iter   = (in_op == MUL) || (in_op == DIV) || (in_op == MOD);
   assign cnt_last  = (cnt_r == CNT_W'(1));

   assign a_neg_in = in_signed & in_a[WIDTH-1];
   assign b_neg_in = in_signed & in_b[WIDTH-1];
   assign a_mag_in = WIDTH'(abs_w(word_t'(in_a), a_neg_in));
   assign b_mag_in = WIDTH'(abs_w(word_t'(in_b), b_neg_in));

   always_comb begin
      fast_res = '0;
      case (in_op)
         ADD:     fast_res = in_a + in_b;
         SUB:     fast_res = in_a - in_b;
         default: fast_res = '0;
      endcase
   end

   assign div_start = accept && ((in_op == DIV) || (in_op == MOD));
   assign div_step  = (state == BUSY) && div_busy;

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .step     (div_step),
      .last     (cnt_last),
      .dividend (a_mag_in),
      .divisor  (b_mag_in),
      .busy     (div_busy),
      .done     (div_done),
      .quo      (div_quo),
      .rem      (div_rem),
      .dz       (div_dz)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op_r       <= ADD;
         a_r        <= '0;
         a_neg_r    <= 1'b0;
         prod_neg_r <= 1'b0;
         fast_r     <= '0;
         acc_r      <= '0;
         mc_r       <= '0;
         mp_r       <= '0;
         cnt_r      <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_r       <= op_t'(in_op);
            a_r        <= in_a;
            a_neg_r    <= a_neg_in;
            prod_neg_r <= a_neg_in ^ b_neg_in;
            fast_r     <= fast_res;
            acc_r      <= '0;
            mc_r       <= a_mag_in;
            mp_r       <= b_mag_in;
            cnt_r      <= CNT_W'(WIDTH);
         end else if (state == BUSY) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (op_r == MUL) begin
               // only the low WIDTH product bits survive, so the accumulator stays WIDTH wide
               if (mp_r[0])
                  acc_r <= acc_r + mc_r;
               mc_r <= mc_r << 1;
               mp_r <= mp_r >> 1;
            end
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = in_iter ? BUSY : DONE;
         BUSY: if ((op_r == MUL) ? cnt_last : div_done) state_nx = DONE;
         DONE: if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      res_c = fast_r;
      dz_c  = 1'b0;
      case (op_r)
         MUL: res_c = apply_sign(acc_r, prod_neg_r);
         DIV: begin
            dz_c  = div_dz;
            res_c = div_dz ? '1 : apply_sign(div_quo, prod_neg_r);
         end
         MOD: begin
            dz_c  = div_dz;
            res_c = div_dz ? a_r : apply_sign(div_rem, a_neg_r);
         end
         default: res_c = fast_r;
      endcase
      out_res = (state == DONE) ? res_c : '0;
      out_dz  = (state == DONE) && dz_c;
   end

endmodule
